// File: rtl/framebuffer_cmd_scheduler_pkg.sv
// State encoding and a lowest-set-bit encoder shared by the framebuffer
// command scheduler.
package FrameBufferSchedulerPkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StCommitIssue,
        StCommitWait,
        StMemsetIssue,
        StMemsetWait,
        StDone
    } state_e;

    localparam int unsigned MaxTargets = 8;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic int lowest_set_index(input logic [MaxTargets-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MaxTargets - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/framebuffer_cmd_scheduler.sv
// Drains the fragment pipeline, then runs commits one target at a time
// (shared AXIS stream) and memset-only targets together in one apply.
module framebuffer_cmd_scheduler
    import FrameBufferSchedulerPkg::*;
#(
    parameter int unsigned NUMBER_OF_TARGETS = 3,
    localparam int unsigned SEL_WIDTH =
        (NUMBER_OF_TARGETS > 1) ? $clog2(NUMBER_OF_TARGETS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_cmd_valid,
    output logic                         s_cmd_ready,
    input  logic [NUMBER_OF_TARGETS-1:0] s_cmd_commitMask,
    input  logic [NUMBER_OF_TARGETS-1:0] s_cmd_memsetMask,
    input  logic                         pipelineIdle,
    output logic                         fragHalt,
    output logic [NUMBER_OF_TARGETS-1:0] apply,
    output logic [NUMBER_OF_TARGETS-1:0] cmdCommit,
    output logic [NUMBER_OF_TARGETS-1:0] cmdMemset,
    input  logic [NUMBER_OF_TARGETS-1:0] applied,
    output logic [SEL_WIDTH-1:0]         streamSel,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned N = NUMBER_OF_TARGETS;

    state_e               r_state;
    state_e               w_state_next;
    logic [N-1:0]         r_pend_commit;
    logic [N-1:0]         r_pend_memset;
    logic [N-1:0]         r_issued;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_guard;
    logic [SEL_WIDTH-1:0] w_low_sel;
    logic [N-1:0]         w_commit_onehot;
    logic [MaxTargets-1:0] w_commit_ext;
    logic                 w_issued_applied;

    always_comb begin
        w_commit_ext        = '0;
        w_commit_ext[N-1:0] = r_pend_commit;
    end

    assign w_low_sel        = SEL_WIDTH'(lowest_set_index(w_commit_ext));
    assign w_commit_onehot  = r_pend_commit & (~r_pend_commit + N'(1));
    assign w_issued_applied = &(applied | ~r_issued);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first WAIT cycle ignores applied while the FrameBuffer picks up the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_commit <= '0;
            r_pend_memset <= '0;
            r_issued      <= '0;
            r_sel         <= '0;
            r_guard       <= 1'b0;
        end else begin
            r_guard <= (r_state == StCommitIssue) || (r_state == StMemsetIssue);
            case (r_state)
                StIdle: begin
                    if (s_cmd_valid) begin
                        r_pend_commit <= s_cmd_commitMask;
                        r_pend_memset <= s_cmd_memsetMask;
                    end
                end
                StCommitIssue: begin
                    r_pend_commit <= r_pend_commit & ~w_commit_onehot;
                    r_pend_memset <= r_pend_memset & ~w_commit_onehot;
                    r_sel         <= w_low_sel;
                end
                StMemsetIssue: begin
                    r_issued      <= r_pend_memset;
                    r_pend_memset <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (s_cmd_valid) begin
                    w_state_next = ((s_cmd_commitMask | s_cmd_memsetMask) == '0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (pipelineIdle) begin
                    w_state_next = (r_pend_commit != '0) ? StCommitIssue : StMemsetIssue;
                end
            end
            StCommitIssue: w_state_next = StCommitWait;
            StCommitWait: begin
                if (!r_guard && applied[r_sel]) begin
                    if (r_pend_commit != '0) begin
                        w_state_next = StCommitIssue;
                    end else if (r_pend_memset != '0) begin
                        w_state_next = StMemsetIssue;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StMemsetIssue: w_state_next = StMemsetWait;
            StMemsetWait: begin
                if (!r_guard && w_issued_applied) begin
                    w_state_next = StDone;
                end
            end
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        s_cmd_ready = 1'b0;
        fragHalt    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        apply       = '0;
        cmdCommit   = '0;
        cmdMemset   = '0;
        streamSel   = r_sel;
        case (r_state)
            StIdle: s_cmd_ready = ~reset;
            StCommitIssue: begin
                apply     = w_commit_onehot;
                cmdCommit = w_commit_onehot;
                cmdMemset = w_commit_onehot & r_pend_memset;
                streamSel = w_low_sel;
            end
            StMemsetIssue: begin
                apply     = r_pend_memset;
                cmdMemset = r_pend_memset;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
        if (r_state != StIdle) begin
            fragHalt = 1'b1;
            busy     = 1'b1;
        end
    end

endmodule

// File: tb/tb_framebuffer_cmd_scheduler.sv
// Self-checking bench: directed and random commands against a reference
// sequence of expected applies, with a behavioural FrameBuffer responder.
module tb_framebuffer_cmd_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_cmd_valid;
    logic          s_cmd_ready;
    logic [N-1:0]  s_cmd_commitMask;
    logic [N-1:0]  s_cmd_memsetMask;
    logic          pipelineIdle;
    logic          fragHalt;
    logic [N-1:0]  apply;
    logic [N-1:0]  cmdCommit;
    logic [N-1:0]  cmdMemset;
    logic [N-1:0]  applied;
    logic [SW-1:0] streamSel;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_sel = 0;
    int arm       [N];
    int hold      [N];
    int lag_of    [N];
    int d_of      [N];
    int force_d   [N];
    int force_lag [N];

    always #5 clk = ~clk;

    framebuffer_cmd_scheduler #(.NUMBER_OF_TARGETS(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_cmd_valid      (s_cmd_valid),
        .s_cmd_ready      (s_cmd_ready),
        .s_cmd_commitMask (s_cmd_commitMask),
        .s_cmd_memsetMask (s_cmd_memsetMask),
        .pipelineIdle     (pipelineIdle),
        .fragHalt         (fragHalt),
        .apply            (apply),
        .cmdCommit        (cmdCommit),
        .cmdMemset        (cmdMemset),
        .applied          (applied),
        .streamSel        (streamSel),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic fb_reset();
        applied = '1;
        for (int i = 0; i < N; i++) begin
            arm[i]  = 0;
            hold[i] = 0;
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, then step the FrameBuffer
    // model: applied drops lag cycles after the pulse, stays low d cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (arm[i] > 0) begin
                arm[i]--;
                if (arm[i] == 0) applied[i] = 1'b0;
            end else if (hold[i] > 0) begin
                hold[i]--;
                if (hold[i] == 0) applied[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (apply[i] === 1'b1) begin
                lag_of[i] = (force_lag[i] >= 0) ? force_lag[i] : int'($urandom_range(0, 1));
                d_of[i]   = (force_d[i] > 0) ? force_d[i] : int'($urandom_range(1, 8));
                arm[i]    = 1 + lag_of[i];
                hold[i]   = d_of[i];
            end
        end
    endtask

    // Offer one command next cycle, hold pipelineIdle low for l cycles, and
    // follow it to its done pulse.
    task automatic run_cmd(input logic [N-1:0] cm, input logic [N-1:0] mm, input int l);
        logic [N-1:0] ev_apply[$];
        logic [N-1:0] ev_commit[$];
        logic [N-1:0] ev_memset[$];
        int           ev_sel[$];
        logic [N-1:0] rem;
        int           c;
        int           next_ev;
        int           done_at;
        int           maxw;
        // Reference: commit targets in ascending order, then leftover memsets at once.
        for (int k = 0; k < N; k++) begin
            if (cm[k]) begin
                ev_apply.push_back(N'(1) << k);
                ev_commit.push_back(N'(1) << k);
                ev_memset.push_back(mm & (N'(1) << k));
                ev_sel.push_back(k);
            end
        end
        rem = mm & ~cm;
        if (rem != '0) begin
            ev_apply.push_back(rem);
            ev_commit.push_back('0);
            ev_memset.push_back(rem);
            ev_sel.push_back(-1);
        end
        tick();
        c = cyc;
        check("ready_idle", s_cmd_ready, 1);
        check("busy_idle", busy, 0);
        s_cmd_valid      = 1'b1;
        s_cmd_commitMask = cm;
        s_cmd_memsetMask = mm;
        pipelineIdle     = (l == 0);
        if (ev_apply.size() == 0) begin
            next_ev = -1;
            done_at = c + 1;
        end else begin
            next_ev = c + 1 + ((l > 1) ? l : 1);
            done_at = -1;
        end
        for (int n = 0; n < 400; n++) begin
            tick();
            s_cmd_valid = 1'b0;
            if (cyc - c == l) pipelineIdle = 1'b1;
            if (cyc == next_ev) begin
                check("apply", apply, ev_apply[0]);
                check("cmdCommit", cmdCommit, ev_commit[0]);
                check("cmdMemset", cmdMemset, ev_memset[0]);
                if (ev_sel[0] >= 0) begin
                    check("streamSel_issue", streamSel, ev_sel[0]);
                    last_sel = ev_sel[0];
                end else begin
                    check("streamSel_hold", streamSel, last_sel);
                end
                maxw = 0;
                for (int i = 0; i < N; i++) begin
                    if (ev_apply[0][i] && (lag_of[i] + d_of[i] > maxw)) maxw = lag_of[i] + d_of[i];
                end
                void'(ev_apply.pop_front());
                void'(ev_commit.pop_front());
                void'(ev_memset.pop_front());
                void'(ev_sel.pop_front());
                if (ev_apply.size() == 0) begin
                    done_at = cyc + 2 + maxw;
                    next_ev = -1;
                end else begin
                    next_ev = cyc + 2 + maxw;
                end
            end else begin
                check("apply_quiet", apply, 0);
                check("cmdCommit_quiet", cmdCommit, 0);
                check("cmdMemset_quiet", cmdMemset, 0);
                check("streamSel_hold", streamSel, last_sel);
            end
            check("done", done, cyc == done_at);
            check("busy", busy, 1);
            check("fragHalt", fragHalt, 1);
            if (cyc == done_at) break;
        end
        if (cyc != done_at) check("done_reached", 32'(cyc), 32'(done_at));
    endtask

    initial begin
        reset            = 1'b1;
        s_cmd_valid      = 1'b0;
        s_cmd_commitMask = '0;
        s_cmd_memsetMask = '0;
        pipelineIdle     = 1'b1;
        for (int i = 0; i < N; i++) begin
            force_d[i]   = 0;
            force_lag[i] = -1;
        end
        fb_reset();
        repeat (3) tick();
        check("rst_ready", s_cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fragHalt", fragHalt, 0);
        check("rst_apply", apply, 0);
        check("rst_streamSel", streamSel, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Single commit, applied low for 10 cycles.
        force_d[0]   = 10;
        force_lag[0] = 0;
        run_cmd(3'b001, 3'b000, 0);
        force_d[0]   = 0;
        force_lag[0] = -1;

        // Commit plus memset: combined applies on 0 and 2, then memset-only on 1.
        run_cmd(3'b101, 3'b111, 0);

        // Parallel memset with staggered applied rises at +3, +7, +12.
        force_d[0] = 2;
        force_d[1] = 6;
        force_d[2] = 11;
        for (int i = 0; i < N; i++) force_lag[i] = 0;
        run_cmd(3'b000, 3'b111, 0);
        for (int i = 0; i < N; i++) begin
            force_d[i]   = 0;
            force_lag[i] = -1;
        end

        // Drain hold for 20 cycles.
        run_cmd(3'b010, 3'b000, 20);

        // Empty command immediately followed by another.
        run_cmd(3'b000, 3'b000, 0);
        run_cmd(3'b100, 3'b001, 0);

        // Reset during COMMIT_WAIT.
        tick();
        check("mid_ready", s_cmd_ready, 1);
        s_cmd_valid      = 1'b1;
        s_cmd_commitMask = 3'b100;
        s_cmd_memsetMask = 3'b000;
        pipelineIdle     = 1'b1;
        force_d[2]       = 20;
        tick();
        s_cmd_valid = 1'b0;
        tick();
        check("mid_apply", apply, 3'b100);
        check("mid_streamSel", streamSel, 2);
        tick();
        check("mid_wait_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_ready", s_cmd_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fragHalt", fragHalt, 0);
        check("mid_rst_apply", apply, 0);
        check("mid_rst_cmdCommit", cmdCommit, 0);
        check("mid_rst_cmdMemset", cmdMemset, 0);
        check("mid_rst_streamSel", streamSel, 0);
        check("mid_rst_done", done, 0);
        reset      = 1'b0;
        force_d[2] = 0;
        last_sel   = 0;
        fb_reset();
        run_cmd(3'b110, 3'b011, 2);

        // Random commands with random drain lengths and response times.
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            run_cmd(N'($urandom), N'($urandom), int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
